// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter in front of the single-ported data RAM (M0 = CPU, M1 = loader/debug).
// Optional RAM_ARB_LOCK_EN adds m1_lock so the loader can hold the RAM for atomic bursts.
module ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [2:0]        m0_access,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [2:0]        m1_access,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_load,
  output logic              ram_store,
  output logic [2:0]        ram_access,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_stall,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               last_owner_r;
  logic               lock_hold_s;
  logic [CNT_W-1:0]   conflict_cnt_r;

  // Lock only matters while M1 already owns the RAM.
  always_comb begin
    lock_hold_s = 1'b0;
`ifdef RAM_ARB_LOCK_EN
    if ((state_r == OWN1) && m1_lock) begin
      lock_hold_s = 1'b1;
    end else begin
      lock_hold_s = 1'b0;
    end
`endif
  end

  // Next owner: lone requester wins, a tie goes to whoever did not own last.
  always_comb begin
    state_s = IDLE;
    if (lock_hold_s) begin
      state_s = OWN1;
    end else if (m0_req && m1_req) begin
      state_s = last_owner_r ? OWN0 : OWN1;
    end else if (m0_req) begin
      state_s = OWN0;
    end else if (m1_req) begin
      state_s = OWN1;
    end else begin
      state_s = IDLE;
    end
  end

  // State, round-robin history and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      last_owner_r   <= 1'b1;
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_s)
        OWN0:    last_owner_r <= 1'b0;
        OWN1:    last_owner_r <= 1'b1;
        default: last_owner_r <= last_owner_r;
      endcase
      if (m0_req && m1_req && (conflict_cnt_r != {CNT_W{1'b1}})) begin
        conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  // RAM port mux and grant decode straight from the owner register.
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_rdata   = {DATA_W{1'b0}};
    m1_rdata   = {DATA_W{1'b0}};
    ram_load   = 1'b0;
    ram_store  = 1'b0;
    ram_access = 3'd0;
    ram_addr   = {ADDR_W{1'b0}};
    ram_wdata  = {DATA_W{1'b0}};
    case (state_r)
      OWN0: begin
        m0_gnt     = 1'b1;
        m0_rdata   = ram_rdata;
        ram_load   = m0_req & ~m0_we;
        ram_store  = m0_req & m0_we;
        ram_access = m0_access;
        ram_addr   = m0_addr;
        ram_wdata  = m0_wdata;
      end
      OWN1: begin
        m1_gnt     = 1'b1;
        m1_rdata   = ram_rdata;
        ram_load   = m1_req & ~m1_we;
        ram_store  = m1_req & m1_we;
        ram_access = m1_access;
        ram_addr   = m1_addr;
        ram_wdata  = m1_wdata;
      end
      default: begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
      end
    endcase
  end

  assign cpu_stall    = m0_req & ~m0_gnt;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a per-cycle owner/memory model plus directed literal checks.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_access, m1_access;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
`ifdef RAM_ARB_LOCK_EN
  logic        m1_lock;
`endif
  logic        m0_gnt, m1_gnt, ram_load, ram_store, cpu_stall;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [2:0]  ram_access;
  logic [15:0] conflict_cnt;

  logic        d2_m0_gnt, d2_m1_gnt, d2_load, d2_store, d2_stall;
  logic [31:0] d2_m0_rdata, d2_m1_rdata, d2_addr, d2_wdata;
  logic [2:0]  d2_access;
  logic [3:0]  cnt4;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_access(m0_access), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_access(m1_access), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata),
`ifdef RAM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cpu_stall(cpu_stall), .conflict_cnt(conflict_cnt)
  );

  ram_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_access(m0_access), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(d2_m0_gnt), .m0_rdata(d2_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_access(m1_access), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata),
`ifdef RAM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_gnt(d2_m1_gnt), .m1_rdata(d2_m1_rdata),
    .ram_load(d2_load), .ram_store(d2_store), .ram_access(d2_access),
    .ram_addr(d2_addr), .ram_wdata(d2_wdata), .ram_rdata(32'd0),
    .cpu_stall(d2_stall), .conflict_cnt(cnt4)
  );

  // Bench RAM: combinational read, word-wide write on the clock edge.
  logic [31:0] mem [0:255];
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) if (ram_store) mem[ram_addr[9:2]] <= ram_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner 0 = none, 1 = M0, 2 = M1; last = id of previous owner.
  int          own, last, mcnt;
  logic [31:0] mmem [0:255];
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    logic        e_load, e_store, both, hold;
    logic [2:0]  e_acc;
    logic [31:0] e_addr, e_wd, e_r0, e_r1;
    e_load = 1'b0; e_store = 1'b0; e_acc = 3'd0; e_addr = 32'd0; e_wd = 32'd0;
    e_r0 = 32'd0; e_r1 = 32'd0;
    if (own == 1) begin
      e_load = m0_req & ~m0_we; e_store = m0_req & m0_we; e_acc = m0_access;
      e_addr = m0_addr; e_wd = m0_wdata; e_r0 = mmem[m0_addr[9:2]];
    end else if (own == 2) begin
      e_load = m1_req & ~m1_we; e_store = m1_req & m1_we; e_acc = m1_access;
      e_addr = m1_addr; e_wd = m1_wdata; e_r1 = mmem[m1_addr[9:2]];
    end
    if (chk_en) begin
      chk("m0_gnt", 64'(m0_gnt), 64'(own == 1));
      chk("m1_gnt", 64'(m1_gnt), 64'(own == 2));
      chk("ram_load", 64'(ram_load), 64'(e_load));
      chk("ram_store", 64'(ram_store), 64'(e_store));
      chk("ram_access", 64'(ram_access), 64'(e_acc));
      chk("ram_addr", 64'(ram_addr), 64'(e_addr));
      chk("ram_wdata", 64'(ram_wdata), 64'(e_wd));
      chk("m0_rdata", 64'(m0_rdata), 64'(e_r0));
      chk("m1_rdata", 64'(m1_rdata), 64'(e_r1));
      chk("cpu_stall", 64'(cpu_stall), 64'(m0_req && own != 1));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(mcnt));
      chk("cnt4", 64'(cnt4), 64'((mcnt > 15) ? 15 : mcnt));
      chk("d4_gnt", 64'({d2_m0_gnt, d2_m1_gnt}), 64'({own == 1, own == 2}));
      chk("d4_stall", 64'(d2_stall), 64'(m0_req && own != 1));
    end
    // Advance the model over the coming edge (inputs are stable until then).
    if (own == 1 && m0_req && m0_we) mmem[m0_addr[9:2]] = m0_wdata;
    if (own == 2 && m1_req && m1_we) mmem[m1_addr[9:2]] = m1_wdata;
    if (rst) begin
      own = 0; last = 1; mcnt = 0;
    end else begin
      both = m0_req && m1_req;
      if (both && mcnt < 65535) mcnt++;
      hold = 1'b0;
`ifdef RAM_ARB_LOCK_EN
      hold = (own == 2) && m1_lock;
`endif
      if (hold)             own = 2;
      else if (both)        begin own = 2 - last; last = 1 - last; end
      else if (m0_req)      begin own = 1; last = 0; end
      else if (m1_req)      begin own = 2; last = 1; end
      else                  own = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    m0_req = 1'b0; m0_we = 1'b0; m0_access = 3'd2; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_access = 3'd2; m1_addr = 32'd0; m1_wdata = 32'd0;
`ifdef RAM_ARB_LOCK_EN
    m1_lock = 1'b0;
`endif
  endtask

  initial begin
    bit g0, g1;
    rst = 1'b1;
    clear_reqs();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'(i) * 32'h01010101;
      mmem[i] = 32'(i) * 32'h01010101;
    end
    mem[4] = 32'hDEADBEEF; mmem[4] = 32'hDEADBEEF;
    own = 0; last = 1; mcnt = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    look();
    chk("rst_gnt", 64'({m0_gnt, m1_gnt}), 64'd0);
    chk("rst_strobes", 64'({ram_load, ram_store}), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);

    // Single M0 load of 0x10.
    cyc();
    m0_req = 1'b1; m0_addr = 32'h10;
    look();
    chk("t1_c1_stall", 64'(cpu_stall), 64'd1);
    chk("t1_c1_gnt", 64'(m0_gnt), 64'd0);
    cyc();
    look();
    chk("t1_c2_gnt", 64'(m0_gnt), 64'd1);
    chk("t1_c2_load", 64'(ram_load), 64'd1);
    chk("t1_c2_addr", 64'(ram_addr), 64'h10);
    chk("t1_c2_rdata", 64'(m0_rdata), 64'hDEADBEEF);
    chk("t1_c2_stall", 64'(cpu_stall), 64'd0);
    cyc();
    clear_reqs();

    // M1 store then M0 load of the same word.
    cyc();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    cyc();
    look();
    chk("t2_m1_gnt", 64'(m1_gnt), 64'd1);
    chk("t2_store", 64'(ram_store), 64'd1);
    cyc();
    clear_reqs();
    m0_req = 1'b1; m0_addr = 32'h20;
    cyc();
    look();
    chk("t2_m0_gnt", 64'(m0_gnt), 64'd1);
    chk("t2_m0_rdata", 64'(m0_rdata), 64'h12345678);
    cyc();
    clear_reqs();

    // Both requesting straight after reset: M0,M1,M0,M1,M0.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      look();
      chk("t3_gnt0", 64'(m0_gnt), 64'(i % 2 == 1));
      chk("t3_gnt1", 64'(m1_gnt), 64'(i >= 2 && i % 2 == 0));
      cyc();
    end
    clear_reqs();
    look();
    chk("t3_cnt", 64'(conflict_cnt), 64'd6);

    // Saturation of the 4-bit counter.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    repeat (20) cyc();
    look();
    chk("t4_cnt4", 64'(cnt4), 64'd15);
    chk("t4_cnt16", 64'(conflict_cnt), 64'd20);
    repeat (5) cyc();
    look();
    chk("t4_cnt4_hold", 64'(cnt4), 64'd15);
    cyc();
    clear_reqs();

    // Reset in the middle of an M1 store grant.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    m1_addr = 32'h30; m1_wdata = $urandom;
    cyc();
    look();
    chk("t5_m0_first", 64'(m0_gnt), 64'd1);
    cyc();
    rst = 1'b1;
    look();
    chk("t5_own1", 64'({m1_gnt, ram_store}), 64'd3);
    cyc();
    rst = 1'b0;
    look();
    chk("t5_idle", 64'({m0_gnt, m1_gnt, ram_store}), 64'd0);
    chk("t5_cnt", 64'(conflict_cnt), 64'd0);
    cyc();
    look();
    chk("t5_m0_again", 64'(m0_gnt), 64'd1);
    cyc();
    clear_reqs();

`ifdef RAM_ARB_LOCK_EN
    // Locked M1 burst holds off M0 for four cycles.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; m1_req = 1'b1; m1_lock = 1'b1;
    cyc();
    m0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m1_lock = 1'b0;
      look();
      chk("t6_m1_gnt", 64'(m1_gnt), 64'd1);
      chk("t6_stall", 64'(cpu_stall), 64'd1);
      cyc();
    end
    look();
    chk("t6_m0_gnt", 64'(m0_gnt), 64'd1);
    cyc();
    clear_reqs();
`endif

    // Random traffic obeying hold-until-grant.
    g0 = 1'b0; g1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      look();
      g0 = m0_gnt; g1 = m1_gnt;
      cyc();
      rst = ($urandom % 200 == 0);
      if (!m0_req || g0) begin
        m0_req = ($urandom % 3 != 0); m0_we = 1'($urandom); m0_access = 3'($urandom);
        m0_addr = 32'($urandom_range(0, 15)) << 2; m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req = ($urandom % 3 != 0); m1_we = 1'($urandom); m1_access = 3'($urandom);
        m1_addr = 32'($urandom_range(0, 15)) << 2; m1_wdata = $urandom;
      end
`ifdef RAM_ARB_LOCK_EN
      m1_lock = m1_req && ($urandom % 4 == 0);
`endif
    end
    look();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter sharing the single data RAM between the CPU load/store port (M0) and a program-loader/debug port (M1).
- Sits between single_cycle_cpu memory-stage signals and the ram instance.
- Produces cpu_stall, which the top level ORs into the CPU halt input while M0 waits.
- Round-robin, registered grant, one RAM access per granted cycle.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM port.
- DATA_W, 32, data width.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- m0_req  in  1  CPU requests an access (load | store).
- m0_we  in  1  1 = store, 0 = load.
- m0_access  in  3  funct3 size/sign code passed to the RAM.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  DATA_W  store data.
- m0_gnt  out  1  M0 owns the RAM this cycle.
- m0_rdata  out  DATA_W  load data; valid when m0_gnt & ~m0_we.
- m1_req, m1_we, m1_access, m1_addr, m1_wdata  in  same as M0  loader/debug request.
- m1_gnt  out  1  M1 owns the RAM this cycle.
- m1_rdata  out  DATA_W  load data for M1.
- ram_load  out  1  to ram.load.
- ram_store  out  1  to ram.store.
- ram_access  out  3  to ram.access.
- ram_addr  out  ADDR_W  to ram.addr.
- ram_wdata  out  DATA_W  to ram.data_in.
- ram_rdata  in  DATA_W  from ram.data_out (combinational read).
- cpu_stall  out  1  m0_req & ~m0_gnt.
- conflict_cnt  out  CNT_W  saturating count of cycles where both reqs are high.

Behaviour:
- States: IDLE, OWN0, OWN1, held in a state register. last_owner is a 1-bit register, reset to 1 so M0 wins the first tie.
- Reset values: state = IDLE, last_owner = 1, conflict_cnt = 0. All gnt, ram_load and ram_store = 0. cpu_stall follows m0_req combinationally.
- Next-state rule (evaluated every cycle, from any state):
  - Exactly one req high: that requester.
  - Both high: the requester != last_owner.
  - None high: IDLE.
- On entering OWNx, last_owner <= x.
- Back-to-back ownership: the current owner keeps the RAM only if the other requester is idle. With both requesters high, ownership alternates every cycle.
- Latency: request seen in cycle N with the arbiter free → gnt asserted in cycle N+1, combinationally from state. Minimum 1-cycle stall per M0 access.
- In OWNx:
  - ram_* driven from Mx inputs: ram_load = ~mx_we & mx_req, ram_store = mx_we & mx_req.
  - mx_gnt = 1.
  - mx_rdata = ram_rdata; the non-owner's rdata = 0.
  - If mx_req has dropped, no RAM strobe is issued; gnt is still asserted but is don't-care.
- In IDLE: ram_load = ram_store = 0; ram_addr, ram_access and ram_wdata = 0.
- Requesters must hold req and all request fields stable until they see gnt. The access completes in the gnt cycle; a store commits at the clk edge that ends the gnt cycle.
- Never grant both requesters in the same cycle; at most one of m0_gnt/m1_gnt is high.
- conflict_cnt increments when m0_req & m1_req, saturating at all-ones. It never wraps.
- rst asserted mid-grant: state → IDLE at that edge and strobes drop next cycle. Whether a store coincident with the rst edge commits is decided by the ram's own reset.

Optional Feature:
- Macro RAM_ARB_LOCK_EN.
- Defined:
  - Adds input m1_lock (1).
  - While state = OWN1 and m1_lock = 1, next state stays OWN1 regardless of m0_req. This lets the loader do atomic multi-word bursts.
  - The lock is ignored in all other states.
  - conflict_cnt still counts.
- Not defined: port absent; pure round-robin as above.

Test Plan:
- Reset, then m0_req=1, m0_we=0, m0_addr=0x10 with ram word 0x10 = 0xDEADBEEF → cycle 1: cpu_stall=1, m0_gnt=0. Cycle 2: m0_gnt=1, ram_load=1, ram_addr=0x10, m0_rdata=0xDEADBEEF, cpu_stall=0.
- m1 store 0x20 ← 0x12345678, then m0 load 0x20 → m1_gnt and ram_store in one cycle, then m0_gnt with m0_rdata=0x12345678.
- Both req held for 6 cycles right after reset → grants M0,M1,M0,M1,M0 (never both); conflict_cnt=6 after the 6th edge.
- Both req continuously with CNT_W=4 for 20 cycles → conflict_cnt saturates at 15 and stays 15.
- rst asserted during OWN1 → next cycle: state IDLE, m1_gnt=0, ram_store=0, conflict_cnt=0, last_owner=1. With both requesters still high, M0 is granted first.
- With RAM_ARB_LOCK_EN defined: m1 granted, m1_lock=1 for 4 cycles while m0_req=1 → m1_gnt=1 for 4 consecutive cycles, cpu_stall=1 throughout. After lock drops, m0_gnt is high in the next cycle.
